// File: rtl/cos_seq_pkg.sv
// Shared definitions for the cos(x) sequencer: alu opcodes, float32
// constants of the order-4 Taylor expansion, FSM state encoding, step
// index type and the per-step control word produced by the step ROM.
package cos_seq_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_FADD = 3'b010;
  localparam logic [2:0] OP_FMUL = 3'b011;

  localparam logic [31:0] C_NHALF = 32'hBF00_0000;  // -0.5
  localparam logic [31:0] C_INV24 = 32'h3D2A_AAAB;  // 1/24
  localparam logic [31:0] C_ONE   = 32'h3F80_0000;  // 1.0

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [2:0] step_t;
  localparam step_t STEP_LAST = 3'd5;

  // Operand sources the top can route onto alu_a / alu_b.
  typedef enum logic [3:0] {
    SRC_ZERO  = 4'd0,
    SRC_X     = 4'd1,
    SRC_T1    = 4'd2,
    SRC_T2    = 4'd3,
    SRC_T3    = 4'd4,
    SRC_T4    = 4'd5,
    SRC_T5    = 4'd6,
    SRC_NHALF = 4'd7,
    SRC_INV24 = 4'd8,
    SRC_ONE   = 4'd9
  } src_t;

  // Register that captures alu_out at the end of a step.
  typedef enum logic [2:0] {
    DST_NONE = 3'd0,
    DST_T1   = 3'd1,
    DST_T2   = 3'd2,
    DST_T3   = 3'd3,
    DST_T4   = 3'd4,
    DST_T5   = 3'd5,
    DST_RES  = 3'd6
  } dst_t;

  typedef struct packed {
    logic [2:0] op;
    src_t       src_a;
    src_t       src_b;
    dst_t       dst;
  } step_ctl_t;

endpackage

// File: rtl/cos_step_rom.sv
// Combinational step table for the cos(x) sequencer.
//   step : current step index 0..5
//   ctl  : {opcode, operand A source, operand B source, destination}
// Indices 6/7 never occur in EXEC; they decode to a harmless NOP.
module cos_step_rom
  import cos_seq_pkg::*;
(
  input  step_t     step,
  output step_ctl_t ctl
);

  always_comb begin
    ctl = '{op: OP_NOP, src_a: SRC_ZERO, src_b: SRC_ZERO, dst: DST_NONE};
    case (step)
      3'd0: ctl = '{op: OP_FMUL, src_a: SRC_X,  src_b: SRC_X,     dst: DST_T1};   // x^2
      3'd1: ctl = '{op: OP_FMUL, src_a: SRC_T1, src_b: SRC_T1,    dst: DST_T2};   // x^4
      3'd2: ctl = '{op: OP_FMUL, src_a: SRC_T1, src_b: SRC_NHALF, dst: DST_T3};   // -x^2/2
      3'd3: ctl = '{op: OP_FMUL, src_a: SRC_T2, src_b: SRC_INV24, dst: DST_T4};   // x^4/24
      3'd4: ctl = '{op: OP_FADD, src_a: SRC_T4, src_b: SRC_T3,    dst: DST_T5};
      3'd5: ctl = '{op: OP_FADD, src_a: SRC_T5, src_b: SRC_ONE,   dst: DST_RES};
      default: ;
    endcase
  end

endmodule

// File: rtl/cos_sequencer.sv
// cos(x) ~= 1 - x^2/2 + x^4/24 on float32, computed by issuing six ops
// in sequence to one shared external alu and holding the intermediates.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start, x        : request and float32 operand (latched on accept in IDLE)
//   busy            : high in EXEC and DONE
//   done            : one-cycle pulse; result valid then and held until next accept
//   result          : float32 cos(x)
//   alu_a/alu_b/alu_op : shared-alu operands and opcode (zero/NOP outside EXEC)
//   alu_out         : shared-alu result, sampled ALU_LAT cycles after operands settle
module cos_sequencer
  import cos_seq_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] x,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT);

  state_t           state;
  step_t            step;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      xr, t1, t2, t3, t4, t5;
  step_ctl_t        ctl;

  cos_step_rom u_rom (
    .step (step),
    .ctl  (ctl)
  );

  function automatic logic [31:0] pick(input src_t s, input logic [31:0] xv,
                                       input logic [31:0] v1, input logic [31:0] v2,
                                       input logic [31:0] v3, input logic [31:0] v4,
                                       input logic [31:0] v5);
    case (s)
      SRC_X:     pick = xv;
      SRC_T1:    pick = v1;
      SRC_T2:    pick = v2;
      SRC_T3:    pick = v3;
      SRC_T4:    pick = v4;
      SRC_T5:    pick = v5;
      SRC_NHALF: pick = C_NHALF;
      SRC_INV24: pick = C_INV24;
      SRC_ONE:   pick = C_ONE;
      default:   pick = 32'h0;
    endcase
  endfunction

  // Alu drive is decoded purely from registered state, so it is stable for
  // the whole step; outside EXEC the alu sees a NOP with zero operands.
  always_comb begin
    alu_op = OP_NOP;
    alu_a  = 32'h0;
    alu_b  = 32'h0;
    if (state == EXEC) begin
      alu_op = ctl.op;
      alu_a  = pick(ctl.src_a, xr, t1, t2, t3, t4, t5);
      alu_b  = pick(ctl.src_b, xr, t1, t2, t3, t4, t5);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'h0;
      step   <= '0;
      cnt    <= '0;
      xr     <= 32'h0;
      t1     <= 32'h0;
      t2     <= 32'h0;
      t3     <= 32'h0;
      t4     <= 32'h0;
      t5     <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            xr    <= x;
            step  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          // Each step holds its operands for ALU_LAT+1 cycles; alu_out is
          // taken on the edge that closes the last of them.
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            case (ctl.dst)
              DST_T1:  t1     <= alu_out;
              DST_T2:  t2     <= alu_out;
              DST_T3:  t3     <= alu_out;
              DST_T4:  t4     <= alu_out;
              DST_T5:  t5     <= alu_out;
              DST_RES: result <= alu_out;
              default: ;
            endcase
            if (step == STEP_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              step <= step + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
